// File: rtl/sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl
//
// Purpose:
//   Valid/ready front end for an external single-port synchronous RAM with
//   per-column write enables. Writes go straight to the RAM and produce no
//   response. Reads return exactly one response each, in acceptance order.
//   A read's data appears on RAM_DO one cycle after acceptance. It is either
//   handed to the consumer directly (bypass) or parked in a 2-entry skid
//   FIFO while the consumer stalls.
//
// Parameters:
//   ADDR_WIDTH  RAM word address width
//   DATA_WIDTH  RAM data width
//   COL_WIDTH   byte-write column width (must divide DATA_WIDTH)
//
// Ports:
//   CLK, RST_N                   clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY          request handshake
//   REQ_WE, REQ_ADDR,
//   REQ_WDATA, REQ_BE            request payload (1 = write)
//   RSP_VALID/RSP_READY          read-response handshake
//   RSP_RDATA                    read data
//   RAM_CE, RAM_RDWEN, RAM_A,
//   RAM_DI, RAM_BW               RAM command (RDWEN 1 = write)
//   RAM_DO                       RAM read data, valid one cycle after a read
// ---------------------------------------------------------------------------
module sp_ram_ctrl #(
    parameter  int ADDR_WIDTH = 10,
    parameter  int DATA_WIDTH = 32,
    parameter  int COL_WIDTH  = 8,
    localparam int NUM_COL    = DATA_WIDTH / COL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    input  logic [NUM_COL-1:0]    REQ_BE,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RAM_CE,
    output logic                  RAM_RDWEN,
    output logic [ADDR_WIDTH-1:0] RAM_A,
    output logic [DATA_WIDTH-1:0] RAM_DI,
    output logic [NUM_COL-1:0]    RAM_BW,
    input  logic [DATA_WIDTH-1:0] RAM_DO
);

    // Column split must be exact, otherwise the byte enables are meaningless.
    generate
        if ((DATA_WIDTH % COL_WIDTH) != 0) begin : g_col_check
            $fatal(1, "sp_ram_ctrl: DATA_WIDTH must be a multiple of COL_WIDTH");
        end
    endgenerate

    localparam int FIFO_DEPTH = 2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];

    logic [2:0]            outstanding;
    logic                  accept;
    logic                  fifo_nonempty;
    logic                  push;
    logic                  pop;

    // -----------------------------------------------------------------------
    // Request side
    // -----------------------------------------------------------------------
    // Outstanding reads are those buffered plus the one whose data arrives
    // this cycle. Capping the total at 2 means a push can never find the
    // FIFO full, even with the consumer stalled indefinitely.
    assign outstanding = {1'b0, count_q} + {2'b00, rd_inflight_q};

    // Gated by RST_N so nothing is accepted while reset is held.
    assign REQ_READY = RST_N & (outstanding < 3'd2);
    assign accept    = REQ_VALID & REQ_READY;

    assign RAM_CE    = accept;
    assign RAM_RDWEN = REQ_WE;
    assign RAM_A     = REQ_ADDR;
    assign RAM_DI    = REQ_WDATA;
    assign RAM_BW    = REQ_WE ? REQ_BE : '0;

    // -----------------------------------------------------------------------
    // Response side
    // -----------------------------------------------------------------------
    assign fifo_nonempty = (count_q != 2'd0);

    assign RSP_VALID = fifo_nonempty | rd_inflight_q;

    // Older buffered data takes priority. With an empty FIFO, the RAM output
    // is forwarded directly so the best-case read latency is one cycle.
    assign RSP_RDATA = fifo_nonempty ? fifo_mem_q[head_q] : RAM_DO;

    // Arriving data is parked unless it leaves through the bypass this cycle.
    assign push = rd_inflight_q & ~(~fifo_nonempty & RSP_READY);
    assign pop  = fifo_nonempty & RSP_READY;

    always_comb begin
        rd_inflight_d = accept & ~REQ_WE;

        head_d = pop  ? ~head_q : head_q;
        tail_d = push ? ~tail_q : tail_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage: only the entry at the tail pointer is written on a push.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_comb begin
                fifo_mem_d[gi] = fifo_mem_q[gi];
                if (push && (tail_q == gi[0])) begin
                    fifo_mem_d[gi] = RAM_DO;
                end
            end

            // Data words carry no reset; the pointers and count decide validity.
            always_ff @(posedge CLK) begin
                fifo_mem_q[gi] <= fifo_mem_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_inflight_q <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

endmodule
